// File: rtl/fft_result_unpacker_pkg.sv
// Shared defaults and FSM encodings for the FFT result stream unpacker.
// Wire format: bins 0..FFT_SIZE-1, each sent as re then im, words MSB byte first.
package fft_result_unpacker_pkg;

    localparam int DEF_FFT_SIZE     = 16;
    localparam int DEF_WORD_SIZE    = 16;
    localparam int DEF_DATA_LENGTH  = 8;
    localparam int DEF_FRACTION     = 8;
    localparam int DEF_TIMEOUT_CLKS = 800;

    localparam int DEF_BPW         = DEF_WORD_SIZE / DEF_DATA_LENGTH;
    localparam int DEF_FRAME_BYTES = DEF_FFT_SIZE * 2 * DEF_BPW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fft_bin_ram.sv
// Single-write, single-registered-read bin RAM; a same-address read/write
// returns the contents from before the write.
module fft_bin_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/fft_result_unpacker.sv
// Reassembles UART bytes into complex FFT bins, stores one frame of bins,
// and flags frame completion or abort (inter-byte timeout / UART error).
module fft_result_unpacker
    import fft_result_unpacker_pkg::*;
#(
    parameter int FFT_SIZE     = DEF_FFT_SIZE,
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int DATA_LENGTH  = DEF_DATA_LENGTH,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_LENGTH-1:0]      i_byte,
    input  logic                        i_byte_valid,
    input  logic                        i_rx_error,
    input  logic [$clog2(FFT_SIZE)-1:0] i_rd_addr,
    output logic [WORD_SIZE-1:0]        o_rd_re,
    output logic [WORD_SIZE-1:0]        o_rd_im,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic                        o_error,
    output logic [7:0]                  o_frame_count
);

    localparam int AW   = $clog2(FFT_SIZE);
    localparam int BPB  = 2 * (WORD_SIZE / DATA_LENGTH);
    localparam int BCW  = $clog2(BPB);
    localparam int TW   = $clog2(TIMEOUT_CLKS);
    localparam int ASMW = 2 * WORD_SIZE - DATA_LENGTH;

    logic [1:0]             state_q, state_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]          bin_q, bin_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [ASMW-1:0]        asm_q, asm_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   we;
    logic                   abort;
    logic [2*WORD_SIZE-1:0] wdata;
    logic [2*WORD_SIZE-1:0] rdata;

    // Holding only the bytes before the last one lets the final byte complete
    // {re, im} combinationally, so the bin is written in its arrival cycle.
    assign wdata = {asm_q, i_byte};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bin_d      = bin_q;
        tmo_d      = tmo_q;
        asm_d      = asm_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        we         = 1'b0;
        abort      = 1'b0;
        case (state_q)
            ST_RECV: begin
                if (i_rx_error) begin
                    abort = 1'b1;
                end else if (i_byte_valid) begin
                    asm_d = wdata[ASMW-1:0];
                    tmo_d = '0;
                    if (byte_cnt_q == BCW'(BPB - 1)) begin
                        we         = 1'b1;
                        byte_cnt_d = '0;
                        if (bin_q == AW'(FFT_SIZE - 1)) begin
                            bin_d   = '0;
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            bin_d = bin_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept the first byte of a new frame.
                state_d = ST_IDLE;
                if (i_byte_valid) begin
                    asm_d      = wdata[ASMW-1:0];
                    byte_cnt_d = BCW'(1);
                    bin_d      = '0;
                    tmo_d      = '0;
                    state_d    = ST_RECV;
                end
            end
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            byte_cnt_d = '0;
            bin_d      = '0;
            tmo_d      = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            bin_q      <= '0;
            tmo_q      <= '0;
            asm_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bin_q      <= bin_d;
            tmo_q      <= tmo_d;
            asm_q      <= asm_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    fft_bin_ram #(
        .DEPTH (FFT_SIZE),
        .WIDTH (2 * WORD_SIZE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (we),
        .i_waddr (bin_q),
        .i_wdata (wdata),
        .i_raddr (i_rd_addr),
        .o_rdata (rdata)
    );

    assign o_rd_re       = rdata[2*WORD_SIZE-1:WORD_SIZE];
    assign o_rd_im       = rdata[WORD_SIZE-1:0];
    assign o_busy        = (state_q == ST_RECV);
    assign o_frame_done  = (state_q == ST_DONE);
    assign o_error       = err_q;
    assign o_frame_count = cnt_q;

endmodule

// File: tb/tb_fft_result_unpacker.sv
// Directed bench for fft_result_unpacker: read-back table plus timeout,
// UART-error, reset and back-to-back frame sequences.
module tb_fft_result_unpacker;
    import fft_result_unpacker_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        i_rx_error;
    logic [3:0]  i_rd_addr;
    logic [15:0] o_rd_re;
    logic [15:0] o_rd_im;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_error;
    logic [7:0]  o_frame_count;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] re;
        logic [15:0] im;
    } rd_vec_t;

    rd_vec_t vecs[5];

    fft_result_unpacker dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .i_rx_error    (i_rx_error),
        .i_rd_addr     (i_rd_addr),
        .o_rd_re       (o_rd_re),
        .o_rd_im       (o_rd_im),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_error       (o_error),
        .o_frame_count (o_frame_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(negedge i_clk) begin
        if (o_frame_done) done_seen++;
        if (o_error) err_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic e);
        i_byte_valid = v;
        i_byte       = b;
        i_rx_error   = e;
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
        i_rx_error   = 1'b0;
    endtask

    function automatic logic [7:0] fbyte(input int idx);
        logic [15:0] w;
        int bin;
        bin = idx / 4;
        w = ((idx % 4) < 2) ? (16'h0100 + 16'(bin)) : (16'hFF00 - 16'(bin));
        return ((idx % 2) == 0) ? w[15:8] : w[7:0];
    endfunction

    task automatic send_bytes(input int first, input int last);
        for (int i = first; i <= last; i++) step(1'b1, fbyte(i), 1'b0);
    endtask

    task automatic read_bin(input logic [3:0] a, input logic [15:0] re,
                            input logic [15:0] im, input string name);
        i_rd_addr = a;
        step(1'b0, 8'h00, 1'b0);
        check({name, "_re"}, 32'(o_rd_re), 32'(re));
        check({name, "_im"}, 32'(o_rd_im), 32'(im));
    endtask

    initial begin
        int d0;
        int e0;
        vecs[0] = '{addr: 4'd5,  re: 16'h0105, im: 16'hFEFB};
        vecs[1] = '{addr: 4'd0,  re: 16'h0100, im: 16'hFF00};
        vecs[2] = '{addr: 4'd15, re: 16'h010F, im: 16'hFEF1};
        vecs[3] = '{addr: 4'd9,  re: 16'h0109, im: 16'hFEF7};
        vecs[4] = '{addr: 4'd1,  re: 16'h0101, im: 16'hFEFF};

        i_rst = 1'b0;
        i_byte = 8'h00;
        i_byte_valid = 1'b0;
        i_rx_error = 1'b0;
        i_rd_addr = 4'd0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_frame_done), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_count", 32'(o_frame_count), 32'd0);
        check("rst_rd_re", 32'(o_rd_re), 32'd0);
        check("rst_rd_im", 32'(o_rd_im), 32'd0);
        i_rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Nominal frame
        d0 = done_seen;
        send_bytes(0, 62);
        check("nom_done_early", 32'(o_frame_done), 32'd0);
        check("nom_busy", 32'(o_busy), 32'd1);
        send_bytes(63, 63);
        check("nom_done", 32'(o_frame_done), 32'd1);
        check("nom_busy_done", 32'(o_busy), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("nom_done_once", 32'(done_seen - d0), 32'd1);
        check("nom_count", 32'(o_frame_count), 32'd1);
        for (int i = 0; i < 5; i++) read_bin(vecs[i].addr, vecs[i].re, vecs[i].im, "nom_rd");

        // Reset mid-frame
        send_bytes(0, 9);
        check("mid_busy", 32'(o_busy), 32'd1);
        #2 i_rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_count", 32'(o_frame_count), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        d0 = done_seen;
        send_bytes(0, FFT_FRAME_LAST());
        check("mid_new_done", 32'(o_frame_done), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("mid_new_count", 32'(o_frame_count), 32'd1);
        check("mid_new_pulses", 32'(done_seen - d0), 32'd1);

        // Timeout after 7 bytes
        d0 = done_seen;
        e0 = err_seen;
        for (int i = 0; i < 7; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 799; i++) step(1'b0, 8'h00, 1'b0);
        check("tmo_no_err_799", 32'(o_error), 32'd0);
        check("tmo_busy_799", 32'(o_busy), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("tmo_err_800", 32'(o_error), 32'd1);
        check("tmo_busy_800", 32'(o_busy), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("tmo_err_clear", 32'(o_error), 32'd0);
        check("tmo_err_once", 32'(err_seen - e0), 32'd1);
        check("tmo_no_done", 32'(done_seen - d0), 32'd0);
        read_bin(4'd0, 16'hA0A1, 16'hA2A3, "tmo_bin0");
        read_bin(4'd1, 16'h0101, 16'hFEFF, "tmo_bin1");

        // Byte lands exactly on the expiry cycle
        e0 = err_seen;
        d0 = done_seen;
        send_bytes(0, 6);
        for (int i = 0; i < 799; i++) step(1'b0, 8'h00, 1'b0);
        send_bytes(7, 7);
        check("race_no_err", 32'(o_error), 32'd0);
        check("race_busy", 32'(o_busy), 32'd1);
        send_bytes(8, FFT_FRAME_LAST());
        check("race_done", 32'(o_frame_done), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("race_err_total", 32'(err_seen - e0), 32'd0);
        check("race_done_total", 32'(done_seen - d0), 32'd1);
        check("race_count", 32'(o_frame_count), 32'd2);

        // rx_error while idle is ignored
        step(1'b0, 8'h00, 1'b1);
        check("idle_rxerr", 32'(o_error), 32'd0);

        // UART error with the 30th byte
        d0 = done_seen;
        send_bytes(0, 28);
        step(1'b1, fbyte(29), 1'b1);
        check("uart_err", 32'(o_error), 32'd1);
        check("uart_busy", 32'(o_busy), 32'd0);
        send_bytes(0, FFT_FRAME_LAST());
        step(1'b0, 8'h00, 1'b0);
        check("uart_next_count", 32'(o_frame_count), 32'd3);
        check("uart_next_done", 32'(done_seen - d0), 32'd1);

        // 256 back-to-back frames from a fresh reset
        i_rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        i_rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        d0 = done_seen;
        e0 = err_seen;
        for (int f = 0; f < 256; f++) begin
            send_bytes(0, FFT_FRAME_LAST());
            if (f == 254) check("b2b_count_255", 32'(o_frame_count), 32'd255);
        end
        check("b2b_last_done", 32'(o_frame_done), 32'd1);
        check("b2b_count_wrap", 32'(o_frame_count), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("b2b_done_pulses", 32'(done_seen - d0), 32'd256);
        check("b2b_no_err", 32'(err_seen - e0), 32'd0);
        check("b2b_idle", 32'(o_busy), 32'd0);
        read_bin(4'd5, 16'h0105, 16'hFEFB, "b2b_rd5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic int FFT_FRAME_LAST();
        return DEF_FRAME_BYTES - 1;
    endfunction

endmodule
